// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART echo controller: FSM states, mode codes, ASCII constants.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        SEND_LF = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ECHO  = 2'b00;
    localparam logic [1:0] MODE_UPPER = 2'b01;
    localparam logic [1:0] MODE_SINK  = 2'b10;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
    endfunction

endpackage

// File: rtl/uart_ctrl_core.sv
// 8N1 UART core with AXI-stream byte ports; one bit lasts prescale*8 clock cycles.
module uart_ctrl_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_prescale,
    input  logic [7:0]  i_s_tdata,
    input  logic        i_s_tvalid,
    output logic        o_s_tready,
    output logic [7:0]  o_m_tdata,
    output logic        o_m_tvalid,
    input  logic        i_m_tready,
    input  logic        i_rxd,
    output logic        o_txd,
    output logic        o_rx_overrun_error,
    output logic        o_rx_frame_error
);
    logic [18:0] w_bit_len;
    logic        r_tx_busy;
    logic [8:0]  r_tx_sh;
    logic [18:0] r_tx_cnt;
    logic [3:0]  r_tx_bits;
    logic        r_txd;
    logic [1:0]  r_rx_s;
    logic        r_rx_busy;
    logic [18:0] r_rx_cnt;
    logic [3:0]  r_rx_bits;
    logic [7:0]  r_rx_sh;
    logic [7:0]  r_m_data;
    logic        r_m_valid;
    logic        r_ovr;
    logic        r_frm;

    assign w_bit_len          = {i_prescale, 3'b000};
    assign o_s_tready         = !r_tx_busy;
    assign o_txd              = r_txd;
    assign o_m_tdata          = r_m_data;
    assign o_m_tvalid         = r_m_valid;
    assign o_rx_overrun_error = r_ovr;
    assign o_rx_frame_error   = r_frm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_busy <= 1'b0;
            r_tx_sh   <= '0;
            r_tx_cnt  <= '0;
            r_tx_bits <= '0;
            r_txd     <= 1'b1;
        end else if (!r_tx_busy) begin
            if (i_s_tvalid) begin
                r_tx_busy <= 1'b1;
                r_tx_sh   <= {1'b1, i_s_tdata};
                r_txd     <= 1'b0;
                r_tx_cnt  <= w_bit_len - 19'd1;
                r_tx_bits <= 4'd9;
            end
        end else if (r_tx_cnt != '0) begin
            r_tx_cnt <= r_tx_cnt - 19'd1;
        end else if (r_tx_bits != '0) begin
            r_txd     <= r_tx_sh[0];
            r_tx_sh   <= {1'b1, r_tx_sh[8:1]};
            r_tx_bits <= r_tx_bits - 4'd1;
            r_tx_cnt  <= w_bit_len - 19'd1;
        end else begin
            r_tx_busy <= 1'b0;
        end
    end

    // rx_bits: 10 = start check, 9..2 = data bits, 1 = stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s    <= 2'b11;
            r_rx_busy <= 1'b0;
            r_rx_cnt  <= '0;
            r_rx_bits <= '0;
            r_rx_sh   <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_ovr     <= 1'b0;
            r_frm     <= 1'b0;
        end else begin
            r_rx_s <= {r_rx_s[0], i_rxd};
            r_ovr  <= 1'b0;
            r_frm  <= 1'b0;
            if (r_m_valid && i_m_tready) r_m_valid <= 1'b0;
            if (!r_rx_busy) begin
                if (!r_rx_s[1]) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= (w_bit_len >> 1) - 19'd1;
                    r_rx_bits <= 4'd10;
                end
            end else if (r_rx_cnt != '0) begin
                r_rx_cnt <= r_rx_cnt - 19'd1;
            end else if (r_rx_bits == 4'd10) begin
                if (r_rx_s[1]) begin
                    r_rx_busy <= 1'b0;
                end else begin
                    r_rx_bits <= 4'd9;
                    r_rx_cnt  <= w_bit_len - 19'd1;
                end
            end else if (r_rx_bits == 4'd1) begin
                r_rx_busy <= 1'b0;
                if (!r_rx_s[1]) begin
                    r_frm <= 1'b1;
                end else if (r_m_valid && !i_m_tready) begin
                    r_ovr <= 1'b1;
                end else begin
                    r_m_data  <= r_rx_sh;
                    r_m_valid <= 1'b1;
                end
            end else begin
                r_rx_sh   <= {r_rx_s[1], r_rx_sh[7:1]};
                r_rx_bits <= r_rx_bits - 4'd1;
                r_rx_cnt  <= w_bit_len - 19'd1;
            end
        end
    end

endmodule

// File: rtl/uart_ctrl_fifo.sv
// Synchronous first-word-fall-through byte FIFO; a push refused when full, a pop ignored when empty.
module uart_ctrl_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [7:0]               i_din,
    input  logic                     i_pop,
    output logic [7:0]               o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] w_level;
    logic        w_push;
    logic        w_pop;

    // Extra pointer bit distinguishes full from empty.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign o_full  = (w_level == (AW + 1)'(DEPTH));
    assign o_empty = (w_level == '0);
    assign o_level = w_level;
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_echo_fifo_ctrl.sv
// UART echo controller: RX FIFO, per-mode transform, debounced button byte, counters and sticky errors.
// Define UART_CTRL_CRLF_EN to follow every echoed CR with an LF.
module uart_echo_fifo_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int         CLK_FREQ     = 100000000,
    parameter int         BAUD         = 9600,
    parameter int         FIFO_DEPTH   = 16,
    parameter int         CNT_WIDTH    = 16,
    parameter int         DEBOUNCE_CYC = 1000000,
    parameter logic [7:0] BTN_CHAR     = 8'h21
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn,
    input  logic [1:0]                    mode,
    input  logic                          uart_rx,
    output logic                          uart_tx,
    output logic [CNT_WIDTH-1:0]          rx_count,
    output logic [CNT_WIDTH-1:0]          tx_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun_err,
    output logic                          frame_err
);
    localparam int          DB_W     = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [15:0] PRESCALE = 16'(CLK_FREQ / (BAUD * 8));

    logic [7:0]           w_rx_data;
    logic                 w_rx_valid;
    logic                 w_tx_ready;
    logic                 w_core_ovr;
    logic                 w_core_frm;
    logic                 w_push;
    logic                 w_pop;
    logic [7:0]           w_fifo_dout;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [1:0]           r_btn_sync;
    logic [DB_W-1:0]      r_db_cnt;
    logic                 r_btn_level;
    logic                 r_btn_pulse;
    logic                 r_btn_pend;
    logic                 w_btn_take;
    state_t               r_state;
    state_t               w_state_next;
    logic [7:0]           r_tx_data;
    logic [7:0]           w_tx_data_next;
    logic                 r_tx_valid;
    logic                 w_tx_valid_next;
    logic [CNT_WIDTH-1:0] r_rx_count;
    logic [CNT_WIDTH-1:0] r_tx_count;
    logic                 r_ovr;
    logic                 r_frm;
`ifdef UART_CTRL_CRLF_EN
    logic                 r_crlf;
    logic                 w_crlf_next;
`endif

    assign w_push = w_rx_valid && !w_fifo_full;

    uart_ctrl_core u_core (
        .clk                (clk),
        .rst                (rst),
        .i_prescale         (PRESCALE),
        .i_s_tdata          (r_tx_data),
        .i_s_tvalid         (r_tx_valid),
        .o_s_tready         (w_tx_ready),
        .o_m_tdata          (w_rx_data),
        .o_m_tvalid         (w_rx_valid),
        .i_m_tready         (!w_fifo_full),
        .i_rxd              (uart_rx),
        .o_txd              (uart_tx),
        .o_rx_overrun_error (w_core_ovr),
        .o_rx_frame_error   (w_core_frm)
    );

    uart_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_rx_data),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    // Debounced level flips only after DEBOUNCE_CYC consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_sync  <= '0;
            r_db_cnt    <= '0;
            r_btn_level <= 1'b0;
            r_btn_pulse <= 1'b0;
            r_btn_pend  <= 1'b0;
        end else begin
            r_btn_sync  <= {r_btn_sync[0], btn};
            r_btn_pulse <= 1'b0;
            if (r_btn_sync[1] == r_btn_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                r_db_cnt    <= '0;
                r_btn_level <= r_btn_sync[1];
                r_btn_pulse <= r_btn_sync[1];
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            if (r_btn_pulse && !r_btn_pend) r_btn_pend <= 1'b1;
            else if (w_btn_take)            r_btn_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_rx_count <= '0;
            r_tx_count <= '0;
            r_ovr      <= 1'b0;
            r_frm      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_valid <= w_tx_valid_next;
            if (w_push)                   r_rx_count <= r_rx_count + 1'b1;
            if (r_tx_valid && w_tx_ready) r_tx_count <= r_tx_count + 1'b1;
            if (w_core_ovr)               r_ovr <= 1'b1;
            if (w_core_frm)               r_frm <= 1'b1;
        end
    end

`ifdef UART_CTRL_CRLF_EN
    always_ff @(posedge clk) begin
        if (rst) r_crlf <= 1'b0;
        else     r_crlf <= w_crlf_next;
    end
`endif

    always_comb begin
        w_state_next    = r_state;
        w_tx_data_next  = r_tx_data;
        w_tx_valid_next = r_tx_valid;
        w_pop           = 1'b0;
        w_btn_take      = 1'b0;
`ifdef UART_CTRL_CRLF_EN
        w_crlf_next     = r_crlf;
`endif
        case (r_state)
            IDLE: begin
                if (r_btn_pend) begin
                    w_btn_take      = 1'b1;
                    w_tx_data_next  = BTN_CHAR;
                    w_tx_valid_next = 1'b1;
                    w_state_next    = SEND;
`ifdef UART_CTRL_CRLF_EN
                    w_crlf_next     = 1'b0;
`endif
                end else if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (mode != MODE_SINK) begin
                        w_tx_data_next  = (mode == MODE_UPPER) ? to_upper(w_fifo_dout) : w_fifo_dout;
                        w_tx_valid_next = 1'b1;
                        w_state_next    = SEND;
`ifdef UART_CTRL_CRLF_EN
                        w_crlf_next     = (w_fifo_dout == CHAR_CR);
`endif
                    end
                end
            end
            SEND: begin
                if (w_tx_ready) begin
                    w_tx_valid_next = 1'b0;
                    w_state_next    = IDLE;
`ifdef UART_CTRL_CRLF_EN
                    if (r_crlf) begin
                        w_tx_data_next  = CHAR_LF;
                        w_tx_valid_next = 1'b1;
                        w_state_next    = SEND_LF;
                    end
`endif
                end
            end
`ifdef UART_CTRL_CRLF_EN
            SEND_LF: begin
                if (w_tx_ready) begin
                    w_tx_valid_next = 1'b0;
                    w_crlf_next     = 1'b0;
                    w_state_next    = IDLE;
                end
            end
`endif
            default: w_state_next = IDLE;
        endcase
    end

    assign rx_count    = r_rx_count;
    assign tx_count    = r_tx_count;
    assign overrun_err = r_ovr;
    assign frame_err   = r_frm;

endmodule

// File: tb/tb_uart_echo_fifo_ctrl.sv
// Directed bench for uart_echo_fifo_ctrl: serial stimulus in, serial decode out, hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_echo_fifo_ctrl;
    localparam int BIT = 96;  // 100 MHz / 1 Mbaud with prescale 12 -> 96 cycles per bit

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic [15:0] rx_count;
    logic [15:0] tx_count;
    logic [2:0]  fifo_level;
    logic        overrun_err;
    logic        frame_err;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  tx_q[$];
    bit          hammer = 1'b0;

    uart_echo_fifo_ctrl #(
        .CLK_FREQ     (100000000),
        .BAUD         (1000000),
        .FIFO_DEPTH   (4),
        .CNT_WIDTH    (16),
        .DEBOUNCE_CYC (16),
        .BTN_CHAR     (8'h21)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .mode        (mode),
        .uart_rx     (uart_rx),
        .uart_tx     (uart_tx),
        .rx_count    (rx_count),
        .tx_count    (tx_count),
        .fifo_level  (fifo_level),
        .overrun_err (overrun_err),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("  ok %s = %0h", tag, got);
        end
    endtask

    // Serial decoder on uart_tx, sampling mid-bit on the falling clock edge.
    initial begin : tx_mon
        logic [7:0] v;
        forever begin
            @(negedge uart_tx);
            repeat (BIT/2) @(negedge clk);
            if (uart_tx == 1'b0) begin
                for (int b = 0; b < 8; b++) begin
                    repeat (BIT) @(negedge clk);
                    v[b] = uart_tx;
                end
                repeat (BIT) @(negedge clk);
                tx_q.push_back(v);
                $display("  uart_tx byte %02h", v);
            end
        end
    end

    task automatic uart_send(input logic [7:0] b, input bit good_stop);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        if (good_stop) begin
            uart_rx = 1'b1;
            repeat (BIT) @(negedge clk);
        end else begin
            uart_rx = 1'b0;
            repeat (60) @(negedge clk);
            uart_rx = 1'b1;
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tx_q.delete();
    endtask

    task automatic wait_tx(input int n, input int max_cyc);
        int c = 0;
        while (tx_q.size() < n && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        check_eq("tx_byte_count", tx_q.size(), n);
    endtask

    task automatic check_tx(input string tag, input logic [7:0] exp);
        logic [31:0] v = 32'hFFFF_FFFF;
        if (tx_q.size() > 0) v = {24'h0, tx_q.pop_front()};
        check_eq(tag, v, {24'h0, exp});
    endtask

    task automatic press(input int hi, input int lo);
        btn = 1'b1;
        repeat (hi) @(negedge clk);
        btn = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0] got_q[$];
        logic [7:0] exp4[5];
        exp4[0] = 8'h30; exp4[1] = 8'h31; exp4[2] = 8'h32; exp4[3] = 8'h33; exp4[4] = 8'h34;

        // Reset state
        do_reset();
        check_eq("rst_uart_tx", uart_tx, 1);
        check_eq("rst_rx_count", rx_count, 0);
        check_eq("rst_tx_count", tx_count, 0);
        check_eq("rst_fifo_level", fifo_level, 0);
        check_eq("rst_overrun", overrun_err, 0);
        check_eq("rst_frame", frame_err, 0);

        // 1: plain echo
        mode = 2'b00;
        uart_send(8'h41, 1'b1);
        wait_tx(1, 2500);
        check_tx("echo_A", 8'h41);
        check_eq("echo_rx_count", rx_count, 1);
        check_eq("echo_tx_count", tx_count, 1);

        // 2: upper-case echo, boundary bytes a, z and the first byte past z
        do_reset();
        mode = 2'b01;
        uart_send(8'h61, 1'b1);
        uart_send(8'h7A, 1'b1);
        uart_send(8'h7B, 1'b1);
        wait_tx(3, 3000);
        check_tx("upper_a", 8'h41);
        check_tx("upper_z", 8'h5A);
        check_tx("upper_brace", 8'h7B);
        check_eq("upper_tx_count", tx_count, 3);

        // 3: sink mode, then a byte with a bad stop bit
        do_reset();
        mode = 2'b10;
        for (int i = 0; i < 5; i++) uart_send(8'h50 + 8'(i), 1'b1);
        repeat (1500) @(negedge clk);
        check_eq("sink_tx_bytes", tx_q.size(), 0);
        check_eq("sink_rx_count", rx_count, 5);
        check_eq("sink_tx_count", tx_count, 0);
        check_eq("sink_fifo_level", fifo_level, 0);
        uart_send(8'h55, 1'b0);
        repeat (200) @(negedge clk);
        check_eq("frame_err_set", frame_err, 1);
        check_eq("frame_rx_count", rx_count, 5);

        // 4: overflow - repeated button presses keep the transmitter busy
        do_reset();
        mode = 2'b00;
        hammer = 1'b1;
        fork
            begin
                while (hammer) press(40, 40);
            end
        join_none
        repeat (300) @(negedge clk);
        for (int i = 0; i < 6; i++) uart_send(8'h30 + 8'(i), 1'b1);
        check_eq("ovf_fifo_level", fifo_level, 4);
        check_eq("ovf_rx_count", rx_count, 4);
        check_eq("ovf_overrun", overrun_err, 1);
        hammer = 1'b0;
        repeat (9000) @(negedge clk);
        check_eq("ovf_drain_level", fifo_level, 0);
        check_eq("ovf_drain_rx_count", rx_count, 5);
        check_eq("ovf_overrun_sticky", overrun_err, 1);
        while (tx_q.size() > 0) begin
            logic [7:0] v;
            v = tx_q.pop_front();
            if (v != 8'h21) got_q.push_back(v);
        end
        check_eq("ovf_echo_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            logic [31:0] v = 32'hFFFF_FFFF;
            if (i < got_q.size()) v = {24'h0, got_q[i]};
            check_eq($sformatf("ovf_echo_%0d", i), v, {24'h0, exp4[i]});
        end
        do_reset();
        check_eq("ovf_overrun_cleared", overrun_err, 0);

        // 5: button glitch ignored, then a real press overtakes a queued byte
        do_reset();
        mode = 2'b00;
        press(3, 1500);
        check_eq("glitch_tx_count", tx_count, 0);
        check_eq("glitch_tx_bytes", tx_q.size(), 0);
        fork
            uart_send(8'h33, 1'b1);
            begin
                repeat (100) @(negedge clk);
                press(20, 10);
            end
        join
        wait_tx(2, 3000);
        check_tx("btn_first", 8'h21);
        check_tx("btn_then_byte", 8'h33);
        check_eq("btn_tx_count", tx_count, 2);
        check_eq("btn_rx_count", rx_count, 1);

        // 6: carriage return, expanded to CR LF only when the option is built in
        do_reset();
        mode = 2'b00;
        uart_send(8'h0D, 1'b1);
        repeat (2500) @(negedge clk);
`ifdef UART_CTRL_CRLF_EN
        check_eq("cr_bytes", tx_q.size(), 2);
        check_tx("cr_first", 8'h0D);
        check_tx("cr_lf", 8'h0A);
        check_eq("cr_tx_count", tx_count, 2);
`else
        check_eq("cr_bytes", tx_q.size(), 1);
        check_tx("cr_only", 8'h0D);
        check_eq("cr_tx_count", tx_count, 1);
`endif

        // 7: reset while a button byte waits in SEND
        do_reset();
        press(30, 60);
        press(30, 60);
        check_eq("midsend_tx_count", tx_count, 1);
        check_eq("midsend_tx_valid", dut.r_tx_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midsend_rst_tx_valid", dut.r_tx_valid, 0);
        check_eq("midsend_rst_tx_count", tx_count, 0);
        check_eq("midsend_rst_rx_count", rx_count, 0);
        check_eq("midsend_rst_uart_tx", uart_tx, 1);
        repeat (2500) @(negedge clk);
        check_eq("midsend_no_retx", tx_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
